// File: rtl/pp_seq_mul.sv
// Iterative shift-add multiplier: one A-gated partial-product row accumulated per clock.
// Optional macro PP_SEQ_ZERO_SKIP_EN ends RUN once no multiplier bits remain.
module pp_seq_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   row;
  logic [CW-1:0]        cnt;
  logic                 last;

  assign row = b_reg[0] ? {{WIDTH{1'b0}}, a_reg} : '0;

`ifdef PP_SEQ_ZERO_SKIP_EN
  // Exit as soon as the bits still to be shifted in are all zero.
  assign last = (cnt == LAST) || ((b_reg >> 1) == '0);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc + (row << cnt);
          b_reg <= b_reg >> 1;
          // Counter holds on the final row so it never wraps.
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: doc/pp_seq_mul.md
# pp_seq_mul

Iterative shift-add multiplier sequencer for the 16-bit multiplier datapath. It owns one partial-product row generator: each cycle the row is `A` gated by the current multiplier bit. The sequencer accumulates one shifted row per clock until the full 2·WIDTH-bit product is formed. It sits beside the Dadda array as a low-area alternative, with valid/ready handshakes on operand input and product output.

## Interface
- `WIDTH`, default 16: operand width. The product is 2·WIDTH bits wide.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operands `a`/`b` are valid.
- `in_ready`, output, 1: the sequencer can accept operands. High only in IDLE.
- `a`, input, WIDTH: multiplicand, unsigned.
- `b`, input, WIDTH: multiplier, unsigned.
- `out_valid`, output, 1: `product` is valid. High only in DONE.
- `out_ready`, input, 1: the consumer accepts `product`.
- `product`, output, 2·WIDTH: registered accumulator value.
- `busy`, output, 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1.
- IDLE, when `in_valid`&`in_ready` at a rising edge:
  - Latch `a_reg`←`a`, `b_reg`←`b`.
  - `acc`←0, `cnt`←0.
  - Next state RUN.
- RUN, on each edge:
  - Row = `b_reg[0]` ? `a_reg` : 0, zero-extended to 2·WIDTH.
  - `acc`←`acc` + (row << `cnt`).
  - `b_reg`←`b_reg`>>1, `cnt`←`cnt`+1.
  - Go to DONE when `cnt`==WIDTH−1, or on early exit (see Configuration).
- DONE: hold `acc`; `product` tracks `acc`. When `out_ready`=1 at an edge, go to IDLE.
- Widths:
  - `acc` is 2·WIDTH bits; the unsigned product never overflows it.
  - `cnt` is $clog2(WIDTH) bits and never wraps within an operation.
- Inputs ignored outside their accept conditions:
  - `in_valid` is ignored when `in_ready`=0.
  - `a`/`b` changes after acceptance have no effect.
- Reset, asynchronous, including mid-RUN or mid-DONE:
  - State←IDLE.
  - `acc`, `a_reg`, `b_reg`, `cnt`←0.
  - The in-flight operation is discarded with no output.
- Output values during and after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0.

## Timing
- Acceptance happens at edge E0.
- Without the Configuration macro:
  - RUN lasts exactly WIDTH cycles.
  - `out_valid` rises after edge E16 (WIDTH=16).
  - The latency is independent of the operand values.
- `product` is stable and equal to a·b for the whole time `out_valid` is high, including under backpressure.
- When `out_ready`=1 at the first DONE edge, `in_ready` is high in the next cycle. The minimum throughput is one operation per WIDTH+2 cycles.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. All handshake outputs decode from state.

## Configuration
- Macro `PP_SEQ_ZERO_SKIP_EN`.
- Defined:
  - RUN also exits to DONE when `b_reg`>>1 == 0 at the current edge, meaning no remaining multiplier bits are set.
  - Latency = index of the highest set bit of `b` + 1 cycles, with a minimum of 1 (`b`=0 or `b`=1 → `out_valid` after E1).
  - The product value is unchanged.
- Undefined: fixed WIDTH-cycle RUN, with no early-exit logic synthesized.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 with random inputs.
  - Required: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0.
  - Stimulus: release reset with `in_valid`=0.
  - Required: outputs unchanged.
- Full-scale operands:
  - Stimulus: `a`=0xFFFF, `b`=0xFFFF.
  - Required: `product`=0xFFFE0001, with `out_valid` high after E16 in both configurations.
- Zero multiplier:
  - Stimulus: `a`=0x1234, `b`=0x0000.
  - Required: `product`=0. `out_valid` after E16 without the macro, after E1 with `PP_SEQ_ZERO_SKIP_EN`.
  - Stimulus: `b`=0x8000 with the macro.
  - Required: still 16 cycles.
- Backpressure:
  - Stimulus: `a`=0x00FF, `b`=0x0101, with `out_ready`=0 for 5 cycles in DONE and `in_valid`=1 pulsed throughout.
  - Required: `product`=0x0000FFFF held stable, `in_ready`=0, and the new operands ignored.
  - Stimulus: raise `out_ready`.
  - Required: IDLE on the next cycle.
- Reset mid-operation:
  - Stimulus: assert `rst_n` low 7 cycles into RUN of 0xABCD×0x1234.
  - Required: immediate IDLE with `out_valid`=0.
  - Stimulus: then `a`=3, `b`=5.
  - Required: `product`=15.
- Back-to-back operations:
  - Stimulus: 0x8000×0x8000 followed by 0x0002×0x0003, with `out_ready` tied high.
  - Required: 0x40000000 then 0x00000006, in_ready gaps of exactly WIDTH+1 cycles without the macro.
